// File: rtl/uxa_ps2_fifo_pkg.sv
// Shared constants for the UXA PS/2 controller byte FIFO.
//   PS2_FIFO_WIDTH : default data width in bits
//   PS2_FIFO_AW    : default pointer width
//   PS2_FIFO_DEPTH : number of slots (one is always left empty)
package uxa_ps2_fifo_pkg;

  localparam int unsigned PS2_FIFO_WIDTH = 8;
  localparam int unsigned PS2_FIFO_AW    = 4;
  localparam int unsigned PS2_FIFO_DEPTH = 1 << PS2_FIFO_AW;

  typedef logic [PS2_FIFO_WIDTH-1:0] ps2_byte_t;

endpackage

// File: rtl/uxa_ps2_fifo_if.sv
// Bus bundle between the PS/2 FIFO and its users.
//   master : producer/consumer side, drives d_i, we_i, wp_inc_i, rp_inc_i
//   slave  : the FIFO, drives q_o, full_o, data_available_o
interface uxa_ps2_fifo_if
  import uxa_ps2_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = PS2_FIFO_WIDTH
);

  logic [WIDTH-1:0] d_i;
  logic             we_i;
  logic             wp_inc_i;
  logic [WIDTH-1:0] q_o;
  logic             rp_inc_i;
  logic             full_o;
  logic             data_available_o;

  modport master (
    output d_i,
    output we_i,
    output wp_inc_i,
    output rp_inc_i,
    input  q_o,
    input  full_o,
    input  data_available_o
  );

  modport slave (
    input  d_i,
    input  we_i,
    input  wp_inc_i,
    input  rp_inc_i,
    output q_o,
    output full_o,
    output data_available_o
  );

endinterface

// File: rtl/uxa_ps2_fifo.sv
// Byte FIFO between PS/2 receive logic and the bus-side reader.
// Writing (we_i) and committing (wp_inc_i) are separate strobes so a byte can be
// staged before it becomes visible to the reader. q_o shows the head slot combinationally;
// rp_inc_i pops it. One slot is kept empty, so 2**AW-1 bytes fit.
// Ports:
//   sys_clk_i   : clock, all state on rising edge
//   sys_reset_i : synchronous active-high reset of both pointers (memory kept)
//   bus         : slave modport of uxa_ps2_fifo_if
module uxa_ps2_fifo
  import uxa_ps2_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = PS2_FIFO_WIDTH,
  parameter int unsigned AW    = PS2_FIFO_AW
) (
  input  logic           sys_clk_i,
  input  logic           sys_reset_i,
  uxa_ps2_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic             full;
  logic             avail;

  // Pointer arithmetic wraps naturally at AW bits.
  assign full  = (wp_q + AW'(1)) == rp_q;
  assign avail = wp_q != rp_q;

  assign bus.full_o           = full;
  assign bus.data_available_o = avail;
  assign bus.q_o              = mem[rp_q];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (bus.wp_inc_i && !full) wp_d = wp_q + AW'(1);
    if (bus.rp_inc_i && avail) rp_d = rp_q + AW'(1);
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_reset_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage is not reset; a write always lands at the pre-edge wp, even when committed
  // in the same cycle.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_reset_i && bus.we_i && !full) begin
      mem[wp_q] <= bus.d_i;
    end
  end

endmodule

// File: tb/tb_uxa_ps2_fifo.sv
module tb_uxa_ps2_fifo;
  import uxa_ps2_fifo_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uxa_ps2_fifo_if #(.WIDTH(8)) bus ();

  uxa_ps2_fifo #(.WIDTH(8), .AW(4)) dut (
    .sys_clk_i   (clk),
    .sys_reset_i (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i     = 1'b0;
    bus.wp_inc_i = 1'b0;
    bus.rp_inc_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.full_o !== 1'b0) begin
      errors++; $display("FAIL reset_full: got %b want 0", bus.full_o);
    end
    checks++;
    if (bus.data_available_o !== 1'b0) begin
      errors++; $display("FAIL reset_avail: got %b want 0", bus.data_available_o);
    end
  endtask

  task automatic test_staged_write();
    bus.d_i = 8'hB7; bus.we_i = 1'b1;
    step();
    idle();
    checks++;
    if (bus.q_o !== 8'hB7) begin
      errors++; $display("FAIL staged_q: got %h want b7", bus.q_o);
    end
    checks++;
    if (bus.data_available_o !== 1'b0) begin
      errors++; $display("FAIL staged_avail: got %b want 0", bus.data_available_o);
    end
    checks++;
    if (bus.full_o !== 1'b0) begin
      errors++; $display("FAIL staged_full: got %b want 0", bus.full_o);
    end
    bus.wp_inc_i = 1'b1;
    step();
    idle();
    checks++;
    if (bus.data_available_o !== 1'b1) begin
      errors++; $display("FAIL commit_avail: got %b want 1", bus.data_available_o);
    end
    checks++;
    if (bus.q_o !== 8'hB7) begin
      errors++; $display("FAIL commit_q: got %h want b7", bus.q_o);
    end
  endtask

  task automatic test_pop();
    bus.rp_inc_i = 1'b1;
    step();
    idle();
    checks++;
    if (bus.data_available_o !== 1'b0) begin
      errors++; $display("FAIL pop_avail: got %b want 0", bus.data_available_o);
    end
    checks++;
    if (bus.full_o !== 1'b0) begin
      errors++; $display("FAIL pop_full: got %b want 0", bus.full_o);
    end
  endtask

  // wp=rp=1 here: a pop on empty must not move rp, so a byte pushed next appears on q_o.
  task automatic test_empty_pop_guard();
    bus.rp_inc_i = 1'b1;
    step();
    idle();
    checks++;
    if (bus.data_available_o !== 1'b0) begin
      errors++; $display("FAIL empty_pop_avail: got %b want 0", bus.data_available_o);
    end
    bus.d_i = 8'h5A; bus.we_i = 1'b1; bus.wp_inc_i = 1'b1;
    step();
    idle();
    checks++;
    if (bus.q_o !== 8'h5A) begin
      errors++; $display("FAIL empty_pop_q: got %h want 5a", bus.q_o);
    end
    checks++;
    if (bus.data_available_o !== 1'b1) begin
      errors++; $display("FAIL empty_pop_push_avail: got %b want 1", bus.data_available_o);
    end
  endtask

  task automatic test_fill_overflow();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int v = 1; v <= 20; v++) begin
      bus.d_i = 8'(v); bus.we_i = 1'b1;
      step();
      idle();
      bus.wp_inc_i = 1'b1;
      step();
      idle();
      if (v == 14) begin
        checks++;
        if (bus.full_o !== 1'b0) begin
          errors++; $display("FAIL fill_full_at14: got %b want 0", bus.full_o);
        end
      end
      if (v == 15) begin
        checks++;
        if (bus.full_o !== 1'b1) begin
          errors++; $display("FAIL fill_full_at15: got %b want 1", bus.full_o);
        end
      end
    end
    checks++;
    if (bus.full_o !== 1'b1) begin
      errors++; $display("FAIL overflow_full: got %b want 1", bus.full_o);
    end
    checks++;
    if (bus.data_available_o !== 1'b1) begin
      errors++; $display("FAIL overflow_avail: got %b want 1", bus.data_available_o);
    end
    checks++;
    if (bus.q_o !== 8'd1) begin
      errors++; $display("FAIL overflow_q: got %h want 01", bus.q_o);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 15; i++) begin
      checks++;
      if (bus.q_o !== 8'(i)) begin
        errors++; $display("FAIL drain_q[%0d]: got %h want %h", i, bus.q_o, 8'(i));
      end
      bus.rp_inc_i = 1'b1;
      step();
      idle();
      if (i == 1) begin
        checks++;
        if (bus.full_o !== 1'b0) begin
          errors++; $display("FAIL drain_first_full: got %b want 0", bus.full_o);
        end
      end
    end
    checks++;
    if (bus.data_available_o !== 1'b0) begin
      errors++; $display("FAIL drain_end_avail: got %b want 0", bus.data_available_o);
    end
    checks++;
    if (bus.full_o !== 1'b0) begin
      errors++; $display("FAIL drain_end_full: got %b want 0", bus.full_o);
    end
  endtask

  // Pointers start at 15 so this also crosses the wrap to 0.
  task automatic test_simultaneous();
    int pops;
    for (int v = 10; v <= 14; v++) begin
      bus.d_i = 8'(v); bus.we_i = 1'b1; bus.wp_inc_i = 1'b1;
      step();
      idle();
    end
    bus.d_i = 8'd15; bus.we_i = 1'b1; bus.wp_inc_i = 1'b1; bus.rp_inc_i = 1'b1;
    step();
    idle();
    checks++;
    if (bus.q_o !== 8'd11) begin
      errors++; $display("FAIL simul_q: got %h want 0b", bus.q_o);
    end
    pops = 0;
    while (bus.data_available_o === 1'b1 && pops < 20) begin
      checks++;
      if (bus.q_o !== 8'(11 + pops)) begin
        errors++; $display("FAIL simul_drain_q[%0d]: got %h want %h", pops, bus.q_o,
                           8'(11 + pops));
      end
      bus.rp_inc_i = 1'b1;
      step();
      idle();
      pops++;
    end
    checks++;
    if (pops != 5) begin
      errors++; $display("FAIL simul_count: got %0d want 5", pops);
    end
  endtask

  task automatic test_full_pop();
    for (int v = 1; v <= 15; v++) begin
      bus.d_i = 8'(100 + v); bus.we_i = 1'b1; bus.wp_inc_i = 1'b1;
      step();
      idle();
    end
    checks++;
    if (bus.full_o !== 1'b1) begin
      errors++; $display("FAIL fullpop_pre_full: got %b want 1", bus.full_o);
    end
    bus.d_i = 8'd200; bus.we_i = 1'b1; bus.wp_inc_i = 1'b1; bus.rp_inc_i = 1'b1;
    step();
    idle();
    checks++;
    if (bus.full_o !== 1'b0) begin
      errors++; $display("FAIL fullpop_full: got %b want 0", bus.full_o);
    end
    checks++;
    if (bus.q_o !== 8'd102) begin
      errors++; $display("FAIL fullpop_q: got %h want 66", bus.q_o);
    end
    bus.d_i = 8'd201; bus.we_i = 1'b1; bus.wp_inc_i = 1'b1;
    step();
    idle();
    checks++;
    if (bus.full_o !== 1'b1) begin
      errors++; $display("FAIL fullpop_refill_full: got %b want 1", bus.full_o);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int v = 0; v < 3; v++) begin
      bus.d_i = 8'(v); bus.we_i = 1'b1; bus.wp_inc_i = 1'b1;
      step();
    end
    rst = 1'b1; bus.rp_inc_i = 1'b1;
    step();
    rst = 1'b0;
    idle();
    checks++;
    if (bus.data_available_o !== 1'b0) begin
      errors++; $display("FAIL midreset_avail: got %b want 0", bus.data_available_o);
    end
    checks++;
    if (bus.full_o !== 1'b0) begin
      errors++; $display("FAIL midreset_full: got %b want 0", bus.full_o);
    end
    checks++;
    if (bus.q_o !== 8'd0) begin
      errors++; $display("FAIL midreset_q: got %h want 00", bus.q_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus.d_i = '0;
    idle();
    #2;
    test_reset();
    test_staged_write();
    test_pop();
    test_empty_pop_guard();
    test_fill_overflow();
    test_drain();
    test_simultaneous();
    test_full_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
